lsu_store_wr: RTL and testbench

Store-side write engine of the c7b load/store unit, the write counterpart of the ld.b/bu/h/hu load path. It accepts one st.b/st.h/st.w request at a time from the core's memory stage and formats the store data into lane-replicated write data with byte strobes. It issues the write on the AXI-style AW/W/B channels toward the top-level memory, then reports completion or error back to the core. Misaligned stores are rejected locally without any bus activity.

---
 rtl/lsu_store_wr.sv | 156 +++++++++++++++
 tb/tb_lsu_store_wr.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_wr.sv
// Store-side write engine: formats st.b/st.h/st.w data into lane-replicated
// write data with byte strobes, issues one AW/W beat, and reports the B response.
module lsu_store_wr #(
    parameter int         ADDR_W = 32,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done_valid,
    output logic              done_err,
    output logic              done_ale,
    output logic [3:0]        awid,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t            state, state_d;
    logic              aw_q, aw_d, w_q, w_d;
    logic              dv_q, dv_d, de_q, de_d, da_q, da_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q, fmt_data;
    logic [3:0]        wstrb_q, fmt_strb;
    logic              aligned, accept;

    assign accept = req_valid && (state == IDLE);

    // Alignment check and lane formatting of the incoming request.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        aligned  = 1'b0;
        fmt_data = req_data;
        fmt_strb = 4'b0000;
        case (req_size)
            2'b00: begin
                aligned  = 1'b1;
                fmt_data = {4{req_data[7:0]}};
                fmt_strb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                aligned  = ~req_addr[0];
                fmt_data = {2{req_data[15:0]}};
                fmt_strb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                aligned  = (req_addr[1:0] == 2'b00);
                fmt_strb = 4'b1111;
            end
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        aw_d    = aw_q;
        w_d     = w_q;
        dv_d    = 1'b0;
        de_d    = 1'b0;
        da_d    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (aligned) begin
                        state_d = SEND;
                        aw_d    = 1'b1;
                        w_d     = 1'b1;
                    end else begin
                        dv_d = 1'b1;
                        de_d = 1'b1;
                        da_d = 1'b1;
                    end
                end
            end
            SEND: begin
                // Each channel retires on its own handshake; both done means the beat is out.
                aw_d = aw_q & ~awready;
                w_d  = w_q & ~wready;
                if (!aw_d && !w_d) state_d = RESP;
            end
            RESP: begin
                if (bvalid) begin
                    state_d = IDLE;
                    dv_d    = 1'b1;
                    de_d    = (bresp != 2'b00);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            aw_q  <= 1'b0;
            w_q   <= 1'b0;
            dv_q  <= 1'b0;
            de_q  <= 1'b0;
            da_q  <= 1'b0;
        end else begin
            state <= state_d;
            aw_q  <= aw_d;
            w_q   <= w_d;
            dv_q  <= dv_d;
            de_q  <= de_d;
            da_q  <= da_d;
        end
    end

    // NOTE: the request latches are reset too, because they drive the bus outputs directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
        end else if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= fmt_data;
            wstrb_q <= fmt_strb;
        end
    end

    assign req_ready  = (state == IDLE);
    assign bready     = (state == RESP);
    assign awvalid    = aw_q;
    assign wvalid     = w_q;
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, size_q};
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wlast      = 1'b1;
    assign awid       = AXI_ID;
    assign done_valid = dv_q;
    assign done_err   = de_q;
    assign done_ale   = da_q;

endmodule

// File: tb/tb_lsu_store_wr.sv
// Directed bench for lsu_store_wr: each scenario task drives a store and
// compares outputs against hand-computed values one step after each rising edge.
module tb_lsu_store_wr;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        done_valid, done_err, done_ale;
    logic [3:0]  awid;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_store_wr #(.ADDR_W(32), .AXI_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size),
        .done_valid(done_valid), .done_err(done_err), .done_ale(done_ale),
        .awid(awid), .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    // {awvalid, wvalid, bready, req_ready} and {done_valid, done_err, done_ale}
    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        tick();
        tick();
        vectors++;
        if ({awvalid, wvalid, bready, req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0001", {awvalid, wvalid, bready, req_ready});
        end
        vectors++;
        if ({done_valid, done_err, done_ale} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 000", {done_valid, done_err, done_ale});
        end
        vectors++;
        if ({awaddr, wdata, wstrb, awsize, wlast, awid} !== {32'h0, 32'h0, 4'h0, 3'd0, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL reset_bus: awaddr=%h wdata=%h wstrb=%b awsize=%0d wlast=%b awid=%0d",
                     awaddr, wdata, wstrb, awsize, wlast, awid);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        vectors++;
        if ({awvalid, wvalid, bready, req_ready, done_valid} !== 5'b00010) begin
            miscompares++;
            $display("FAIL reset_release: got %b want 00010", {awvalid, wvalid, bready, req_ready, done_valid});
        end
    endtask

    task automatic test_store_byte();
        awready = 1'b1; wready = 1'b1;
        drive_req(32'h1c001003, 32'h12345678, 2'b00);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, wvalid, bready, req_ready} !== 4'b1100) begin
            miscompares++;
            $display("FAIL byte_send_ctl: got %b want 1100", {awvalid, wvalid, bready, req_ready});
        end
        vectors++;
        if ({awaddr, awsize, wdata, wstrb, wlast} !== {32'h1c001003, 3'd0, 32'h78787878, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL byte_bus: awaddr=%h awsize=%0d wdata=%h wstrb=%b wlast=%b want 1c001003/0/78787878/1000/1",
                     awaddr, awsize, wdata, wstrb, wlast);
        end
        tick();
        vectors++;
        if ({awvalid, wvalid, bready, req_ready, done_valid} !== 5'b00100) begin
            miscompares++;
            $display("FAIL byte_resp_ctl: got %b want 00100", {awvalid, wvalid, bready, req_ready, done_valid});
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        vectors++;
        if ({done_valid, done_err, done_ale, req_ready, bready} !== 5'b10010) begin
            miscompares++;
            $display("FAIL byte_done: got %b want 10010", {done_valid, done_err, done_ale, req_ready, bready});
        end
        tick();
        vectors++;
        if (done_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_done_pulse: got %b want 0", done_valid);
        end
    endtask

    task automatic test_back_to_back();
        awready = 1'b1; wready = 1'b1;
        drive_req(32'h1c001002, 32'h0000abcd, 2'b01);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, wdata, wstrb, awsize} !== {1'b1, 32'habcdabcd, 4'b1100, 3'd1}) begin
            miscompares++;
            $display("FAIL half_bus: awvalid=%b wdata=%h wstrb=%b awsize=%0d want 1/abcdabcd/1100/1",
                     awvalid, wdata, wstrb, awsize);
        end
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        vectors++;
        if ({done_valid, done_err, req_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL half_done: got %b want 101", {done_valid, done_err, req_ready});
        end
        drive_req(32'h1c001004, 32'hdeadbeef, 2'b10);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, wvalid, awaddr, wdata, wstrb, awsize} !==
            {1'b1, 1'b1, 32'h1c001004, 32'hdeadbeef, 4'b1111, 3'd2}) begin
            miscompares++;
            $display("FAIL word_b2b_bus: aw=%b w=%b awaddr=%h wdata=%h wstrb=%b awsize=%0d",
                     awvalid, wvalid, awaddr, wdata, wstrb, awsize);
        end
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        vectors++;
        if ({done_valid, done_err, done_ale} !== 3'b100) begin
            miscompares++;
            $display("FAIL word_b2b_done: got %b want 100", {done_valid, done_err, done_ale});
        end
        tick();
    endtask

    task automatic test_misaligned();
        awready = 1'b0; wready = 1'b0;
        drive_req(32'h1c001001, 32'h11111111, 2'b10);
        tick();
        vectors++;
        if ({done_valid, done_err, done_ale, awvalid, wvalid, req_ready} !== 6'b111001) begin
            miscompares++;
            $display("FAIL misal_word: got %b want 111001", {done_valid, done_err, done_ale, awvalid, wvalid, req_ready});
        end
        drive_req(32'h1c001005, 32'h00002222, 2'b01);
        tick();
        vectors++;
        if ({done_valid, done_err, done_ale, awvalid, wvalid, req_ready} !== 6'b111001) begin
            miscompares++;
            $display("FAIL misal_half: got %b want 111001", {done_valid, done_err, done_ale, awvalid, wvalid, req_ready});
        end
        drive_req(32'h1c001000, 32'h33333333, 2'b11);
        tick();
        vectors++;
        if ({done_valid, done_err, done_ale, awvalid, wvalid, req_ready} !== 6'b111001) begin
            miscompares++;
            $display("FAIL misal_rsvd: got %b want 111001", {done_valid, done_err, done_ale, awvalid, wvalid, req_ready});
        end
        req_valid = 1'b0;
        tick();
        vectors++;
        if ({done_valid, awvalid, wvalid, req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL misal_after: got %b want 0001", {done_valid, awvalid, wvalid, req_ready});
        end
    endtask

    task automatic test_skew_aw();
        awready = 1'b0; wready = 1'b1;
        drive_req(32'h1c001000, 32'h000000a5, 2'b00);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, wvalid, wdata, wstrb} !== {1'b1, 1'b1, 32'ha5a5a5a5, 4'b0001}) begin
            miscompares++;
            $display("FAIL skew_aw_entry: aw=%b w=%b wdata=%h wstrb=%b", awvalid, wvalid, wdata, wstrb);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({awvalid, wvalid, bready, wdata} !== {3'b100, 32'ha5a5a5a5}) begin
                miscompares++;
                $display("FAIL skew_aw_hold[%0d]: aw/w/bready=%b wdata=%h want 100/a5a5a5a5",
                         i, {awvalid, wvalid, bready}, wdata);
            end
        end
        awready = 1'b1;
        tick();
        vectors++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            miscompares++;
            $display("FAIL skew_aw_resp: got %b want 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        vectors++;
        if ({done_valid, done_err, done_ale} !== 3'b100) begin
            miscompares++;
            $display("FAIL skew_aw_done: got %b want 100", {done_valid, done_err, done_ale});
        end
    endtask

    task automatic test_skew_w();
        awready = 1'b1; wready = 1'b0;
        drive_req(32'h1c001006, 32'h00001234, 2'b01);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, wvalid, wdata, wstrb, awsize} !== {1'b1, 1'b1, 32'h12341234, 4'b1100, 3'd1}) begin
            miscompares++;
            $display("FAIL skew_w_entry: aw=%b w=%b wdata=%h wstrb=%b awsize=%0d",
                     awvalid, wvalid, wdata, wstrb, awsize);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({awvalid, wvalid, bready, awaddr} !== {3'b010, 32'h1c001006}) begin
                miscompares++;
                $display("FAIL skew_w_hold[%0d]: aw/w/bready=%b awaddr=%h want 010/1c001006",
                         i, {awvalid, wvalid, bready}, awaddr);
            end
        end
        wready = 1'b1;
        tick();
        vectors++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            miscompares++;
            $display("FAIL skew_w_resp: got %b want 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        vectors++;
        if ({done_valid, done_err, done_ale} !== 3'b100) begin
            miscompares++;
            $display("FAIL skew_w_done: got %b want 100", {done_valid, done_err, done_ale});
        end
    endtask

    task automatic test_bresp_err();
        awready = 1'b1; wready = 1'b1;
        drive_req(32'h1c002000, 32'hcafef00d, 2'b10);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bready, done_valid, req_ready} !== 3'b100) begin
                miscompares++;
                $display("FAIL bresp_wait[%0d]: got %b want 100", i, {bready, done_valid, req_ready});
            end
            tick();
        end
        bvalid = 1'b1; bresp = 2'b10;
        vectors++;
        if (bready !== 1'b1) begin
            miscompares++;
            $display("FAIL bresp_bready: got %b want 1", bready);
        end
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        vectors++;
        if ({done_valid, done_err, done_ale} !== 3'b110) begin
            miscompares++;
            $display("FAIL bresp_done: got %b want 110", {done_valid, done_err, done_ale});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        awready = 1'b0; wready = 1'b0;
        drive_req(32'h1c003000, 32'h0badf00d, 2'b10);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, wvalid} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_send: got %b want 11", {awvalid, wvalid});
        end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({awvalid, wvalid, bready, req_ready, done_valid, awaddr, wdata} !==
            {5'b00010, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL rstmid_async: ctl=%b awaddr=%h wdata=%h want 00010/0/0",
                     {awvalid, wvalid, bready, req_ready, done_valid}, awaddr, wdata);
        end
        tick();
        @(negedge clk);
        resetn = 1'b1;
        awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({awvalid, wvalid, bready, req_ready, done_valid} !== 5'b00010) begin
                miscompares++;
                $display("FAIL rstmid_after[%0d]: got %b want 00010", i, {awvalid, wvalid, bready, req_ready, done_valid});
            end
        end
        drive_req(32'h1c003002, 32'h000000ee, 2'b00);
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({awvalid, awaddr, wdata, wstrb} !== {1'b1, 32'h1c003002, 32'heeeeeeee, 4'b0100}) begin
            miscompares++;
            $display("FAIL rstmid_next_bus: aw=%b awaddr=%h wdata=%h wstrb=%b", awvalid, awaddr, wdata, wstrb);
        end
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        vectors++;
        if ({done_valid, done_err, done_ale} !== 3'b100) begin
            miscompares++;
            $display("FAIL rstmid_next_done: got %b want 100", {done_valid, done_err, done_ale});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_back_to_back();
        test_misaligned();
        test_skew_aw();
        test_skew_w();
        test_bresp_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
